// File: rtl/clk_measure_pkg.sv
// Shared types and constants for the clock/period measurement block.
package clk_measure_pkg;

  // Default width of the cycle counters and measurement outputs.
  localparam int CNT_W_DEFAULT = 32;

  // Measurement FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for the first rising edge
    RUN   = 2'd1,  // timing a period
    STALL = 2'd2   // edge lost; current interval cannot be trusted
  } state_e;

endpackage

// File: rtl/clk_measure_sync_edge.sv
// Input synchronizer with edge detection. A rise is only reported once the
// synchronized input has been seen low after reset. This keeps an input that
// is already high at reset release from producing a false rising edge.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;   // marks which chain stages hold real samples
  logic                   hist_q;
  logic                   armed_q;  // set once a genuine low has been observed

  // Shift the input through the chain and track history and arming.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      fill_q  <= '0;
      hist_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      hist_q <= sync_q[SYNC_STAGES-1];
      if (fill_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = armed_q & sync & ~hist_q;
  assign fall = ~sync & hist_q;

endmodule

// File: rtl/clk_measure.sv
// Measures the period and high time of an asynchronous square wave in
// clk_input cycles, with optional stall detection when edges stop arriving.
module clk_measure
  import clk_measure_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_input,
  input  logic             reset,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] timeout,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic sync_s;
  logic rise_s;
  logic fall_s;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk_i (clk_input),
    .rst_i (reset),
    .sig_i (sig_in),
    .sync  (sync_s),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [CNT_W-1:0] high_cap_q,  high_cap_d;
  logic             high_seen_q, high_seen_d;
  logic [CNT_W-1:0] period_q,    period_d;
  logic [CNT_W-1:0] high_q,      high_d;
  logic             valid_q,     valid_d;
  logic             stalled_q,   stalled_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  // Saturating increment and stall comparison against the live timeout.
  always_comb begin
    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    timeout_hit = (timeout != '0) && (cnt_q >= timeout);
  end

  // Next-state and measurement logic; a rise always wins over a timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    high_cap_d  = high_cap_q;
    high_seen_d = high_seen_q;
    period_d    = period_q;
    high_d      = high_q;
    valid_d     = 1'b0;
    stalled_d   = stalled_q;

    case (state_q)
      IDLE: begin
        if (rise_s) begin
          cnt_d       = CNT_ONE;
          high_cap_d  = '0;
          high_seen_d = 1'b0;
          state_d     = RUN;
        end
      end

      RUN: begin
        if (rise_s) begin
          period_d    = cnt_q;
          high_d      = high_cap_q;
          valid_d     = 1'b1;
          cnt_d       = CNT_ONE;
          high_cap_d  = '0;
          high_seen_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          if (fall_s && !high_seen_q) begin
            high_cap_d  = cnt_q;
            high_seen_d = 1'b1;
          end
          if (timeout_hit) begin
            state_d   = STALL;
            stalled_d = 1'b1;
          end
        end
      end

      STALL: begin
        if (rise_s) begin
          stalled_d   = 1'b0;
          cnt_d       = CNT_ONE;
          high_cap_d  = '0;
          high_seen_d = 1'b0;
          state_d     = RUN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and measurement registers.
  always_ff @(posedge clk_input or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      high_cap_q  <= '0;
      high_seen_q <= 1'b0;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
      stalled_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      high_cap_q  <= high_cap_d;
      high_seen_q <= high_seen_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      stalled_q   <= stalled_d;
    end
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign valid      = valid_q;
  assign stalled    = stalled_q;

  // The synchronized level itself is not needed by the measurement logic.
  logic unused_sync;
  assign unused_sync = sync_s;

endmodule

// File: tb/tb_clk_measure.sv
// Randomized bench for clk_measure with an edge-index reference model.
module tb_clk_measure;

  localparam int    CNT_W = 8;
  localparam int    SYNC  = 2;
  localparam longint MAXV = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] timeout = '0;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             valid;
  logic             stalled;

  clk_measure #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk_input (clk),
    .reset     (rst),
    .sig_in    (sig_in),
    .timeout   (timeout),
    .period_out(period_out),
    .high_out  (high_out),
    .valid     (valid),
    .stalled   (stalled)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on the sequence of sig_in samples taken at each clock edge: a rise
  // at sample k (after a low has been seen since reset) ends an interval of
  // k - last_rise cycles. Results become visible SYNC+1 edges after the
  // sample, modelled as a FIFO of expected output snapshots.
  typedef struct {
    longint period;
    longint high;
    bit     valid;
    bit     stalled;
  } exp_t;

  exp_t   exp_q[$];
  bit     m_armed, m_prev, m_locked, m_stl, m_fseen;
  longint m_k, m_last, m_fall, m_period, m_high;

  function automatic longint sat(longint x);
    return (x > MAXV) ? MAXV : x;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_armed = 0; m_prev = 0; m_locked = 0; m_stl = 0; m_fseen = 0;
    m_k = 0; m_last = 0; m_fall = 0; m_period = 0; m_high = 0;
  endtask

  task automatic model_step(bit s);
    bit     rise_e;
    bit     fall_e;
    longint d;
    exp_t   e;
    rise_e  = m_armed && s && !m_prev;
    fall_e  = !s && m_prev;
    d       = sat(m_k - m_last);
    e.valid = 0;
    if (rise_e) begin
      if (m_locked && !m_stl) begin
        m_period = d;
        m_high   = m_fseen ? sat(m_fall - m_last) : 0;
        e.valid  = 1;
      end
      m_locked = 1;
      m_stl    = 0;
      m_last   = m_k;
      m_fseen  = 0;
    end else if (m_locked && !m_stl) begin
      if (fall_e && !m_fseen) begin
        m_fseen = 1;
        m_fall  = m_k;
      end
      if (timeout != 0 && d >= longint'(timeout)) m_stl = 1;
    end
    if (!s) m_armed = 1;
    m_prev    = s;
    m_k++;
    e.period  = m_period;
    e.high    = m_high;
    e.stalled = m_stl;
    exp_q.push_back(e);
  endtask

  initial model_reset();

  always @(posedge clk) begin
    if (rst) model_reset();
    else     model_step(sig_in);
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin : mon
    exp_t e;
    e = '{period: 0, high: 0, valid: 0, stalled: 0};
    if (!rst && exp_q.size() > SYNC) e = exp_q.pop_front();
    check("period_out", 64'(period_out), 64'(e.period));
    check("high_out",   64'(high_out),   64'(e.high));
    check("valid",      64'(valid),      64'(e.valid));
    check("stalled",    64'(stalled),    64'(e.stalled));
    if (valid === 1'b1)
      $display("[TB] valid period=%0d high=%0d stalled=%0b", period_out, high_out, stalled);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(bit v);
    @(negedge clk);
    #1;
    sig_in = v;
  endtask

  task automatic hold(bit v, int c);
    for (int i = 0; i < c; i++) cyc(v);
  endtask

  task automatic wave(int p, int h, int n);
    for (int j = 0; j < n; j++) begin
      hold(1'b1, h);
      hold(1'b0, p - h);
    end
  endtask

  task automatic do_reset(int t);
    @(negedge clk);
    #1;
    rst     = 1'b1;
    timeout = CNT_W'(t);
    #1;
    check("rst_period",  64'(period_out), 64'd0);
    check("rst_high",    64'(high_out),   64'd0);
    check("rst_valid",   64'(valid),      64'd0);
    check("rst_stalled", 64'(stalled),    64'd0);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset(0);

    // Period 10, high 4.
    wave(10, 4, 5);
    check("p10_period", 64'(period_out), 64'd10);
    check("p10_high",   64'(high_out),   64'd4);

    // Toggle every cycle.
    wave(2, 1, 8);
    hold(1'b0, 4);
    check("p2_period", 64'(period_out), 64'd2);
    check("p2_high",   64'(high_out),   64'd1);

    // Stall after lock at period 20, then recovery.
    do_reset(50);
    wave(20, 5, 4);
    hold(1'b0, 60);
    check("stall_level",  64'(stalled),    64'd1);
    check("stall_period", 64'(period_out), 64'd20);
    check("stall_high",   64'(high_out),   64'd5);
    wave(15, 5, 1);
    check("relock_stalled", 64'(stalled),    64'd0);
    check("relock_period",  64'(period_out), 64'd20);
    wave(15, 5, 2);
    hold(1'b0, 3);
    check("recover_period", 64'(period_out), 64'd15);

    // Period exactly equal to the timeout: rise wins.
    do_reset(20);
    wave(20, 10, 5);
    hold(1'b0, 3);
    check("tie_period",  64'(period_out), 64'd20);
    check("tie_stalled", 64'(stalled),    64'd0);

    // Reset mid-period while sig_in is high.
    do_reset(0);
    wave(10, 4, 2);
    hold(1'b1, 2);
    do_reset(0);
    hold(1'b1, 6);
    hold(1'b0, 4);
    wave(10, 4, 3);
    hold(1'b0, 2);
    check("post_rst_period", 64'(period_out), 64'd10);
    check("post_rst_high",   64'(high_out),   64'd4);

    // Counter saturation.
    wave(10, 3, 2);
    hold(1'b0, 300);
    hold(1'b1, 3);
    hold(1'b0, 5);
    check("sat_period", 64'(period_out), 64'd255);
    check("sat_high",   64'(high_out),   64'd3);

    // Random waves, timeouts and resets.
    for (int seg = 0; seg < 30; seg++) begin
      int p;
      int h;
      if ($urandom_range(0, 3) == 0)
        do_reset(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(5, 60)));
      p = int'($urandom_range(2, 40));
      h = int'($urandom_range(1, p - 1));
      wave(p, h, int'($urandom_range(1, 4)));
      if ($urandom_range(0, 2) == 0) hold(1'b0, int'($urandom_range(0, 70)));
    end
    hold(1'b0, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
